// File: rtl/wfull_rptr_sync_non2n.sv
// Write-domain status for the non-power-of-2 async FIFO: receives the read
// pointer over a toggle req/ack handshake and produces full/almost_full/count/overflow.
module wfull_rptr_sync_non2n #(
    parameter int FIFO_DEPTH   = 520,
    parameter int PTR_WIDTH    = 10,
    parameter int MEM_SIZE     = 1 << PTR_WIDTH,
    parameter int START_ADDR   = MEM_SIZE/2 - FIFO_DEPTH/2,
    parameter int END_ADDR     = MEM_SIZE/2 + FIFO_DEPTH/2 - 1,
    parameter int AFULL_THRESH = 512,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH-1:0] wptr,
    input  logic [PTR_WIDTH:0]   rptr_data,
    input  logic                 rptr_req,
    output logic                 rptr_ack,
    input  logic                 ovf_clr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wcount,
    output logic                 overflow
);
    localparam int W = PTR_WIDTH + 1;
    localparam logic [W-1:0]         START_W = W'(START_ADDR);
    localparam logic [W-1:0]         DEPTH_W = W'(FIFO_DEPTH);
    localparam logic [W-1:0]         AFULL_W = W'(AFULL_THRESH);
    localparam logic [PTR_WIDTH-1:0] START_P = PTR_WIDTH'(START_ADDR);
    localparam logic [PTR_WIDTH-1:0] END_P   = PTR_WIDTH'(END_ADDR);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_seen;
    logic                   r_ack;
    logic [W-1:0]           r_rptr_s;
    logic                   r_wlap;
    logic [W-1:0]           r_wcount;
    logic                   r_full;
    logic                   r_afull;
    logic                   r_ovf;

    logic                 w_wr;
    logic                 w_wrap;
    logic                 w_req_sync;
    logic                 w_cap;
    logic [PTR_WIDTH-1:0] w_wptr_next;
    logic                 w_wlap_next;
    logic [W-1:0]         w_rptr_n;
    logic [W-1:0]         w_w_off;
    logic [W-1:0]         w_r_off;
    logic [W-1:0]         w_count;

    assign w_wr        = w_en && !r_full;
    assign w_wrap      = w_wr && (wptr == END_P);
    assign w_wptr_next = w_wrap ? START_P : (w_wr ? wptr + PTR_WIDTH'(1) : wptr);
    assign w_wlap_next = r_wlap ^ w_wrap;

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_cap      = (w_req_sync != r_req_seen);
    // Fresh data is folded in on the capture cycle so count tracks rptr_ack exactly.
    assign w_rptr_n   = w_cap ? rptr_data : r_rptr_s;

    assign w_w_off = {1'b0, w_wptr_next} - START_W;
    assign w_r_off = {1'b0, w_rptr_n[PTR_WIDTH-1:0]} - START_W;
    assign w_count = (w_wlap_next == w_rptr_n[PTR_WIDTH]) ? (w_w_off - w_r_off)
                                                          : (DEPTH_W - w_r_off + w_w_off);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_sync     <= '0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_rptr_s   <= {1'b0, START_P};
            r_wlap     <= 1'b0;
            r_wcount   <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rptr_req};
            if (w_cap) begin
                r_rptr_s   <= rptr_data;
                r_req_seen <= w_req_sync;
                r_ack      <= w_req_sync;
            end
            r_wlap   <= w_wlap_next;
            r_wcount <= w_count;
            r_full   <= (w_count == DEPTH_W);
            r_afull  <= (w_count >= AFULL_W);
            if (w_en && r_full)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign rptr_ack    = r_ack;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wcount      = r_wcount;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_wfull_rptr_sync_non2n.sv
// Scoreboard bench for wfull_rptr_sync_non2n with a modelled write-pointer handler.
module tb_wfull_rptr_sync_non2n;
    localparam int DEPTH = 520;
    localparam int START = 252;
    localparam int ENDA  = 771;
    localparam int AF    = 512;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        w_en = 1'b0;
    logic [9:0]  wptr;
    logic [10:0] rptr_data = 11'(START);
    logic        rptr_req = 1'b0;
    logic        rptr_ack;
    logic        ovf_clr = 1'b0;
    logic        full, almost_full, overflow;
    logic [10:0] wcount;

    typedef struct packed {
        logic [10:0] cnt;
        logic        f;
        logic        af;
    } exp_t;
    exp_t q[$];

    int errs = 0;
    int chks = 0;
    int m_cnt = 0;

    wfull_rptr_sync_non2n dut (
        .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .wptr(wptr),
        .rptr_data(rptr_data), .rptr_req(rptr_req), .rptr_ack(rptr_ack),
        .ovf_clr(ovf_clr), .full(full), .almost_full(almost_full),
        .wcount(wcount), .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    // Write-pointer handler model: shares w_en and full with the DUT.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            wptr <= 10'(START);
        else if (w_en && !full)
            wptr <= (wptr == 10'(ENDA)) ? 10'(START) : wptr + 10'd1;
    end

    always @(negedge wclk) begin
        if (wrst_n && wcount > 11'(DEPTH)) begin
            errs++;
            $display("FAIL range: wcount=%0d exceeds %0d", wcount, DEPTH);
        end
    end

    task automatic pop_check(input string nm);
        exp_t e;
        e = q.pop_front();
        chks++;
        if (wcount !== e.cnt || full !== e.f || almost_full !== e.af) begin
            errs++;
            $display("FAIL %s: got cnt=%0d full=%b af=%b, want cnt=%0d full=%b af=%b",
                     nm, wcount, full, almost_full, e.cnt, e.f, e.af);
        end
    endtask

    task automatic test_reset();
        #3;
        chks++;
        if ({rptr_ack, full, almost_full, wcount, overflow} !== 15'd0) begin
            errs++;
            $display("FAIL reset_hold: outputs=%h want 0", {rptr_ack, full, almost_full, wcount, overflow});
        end
        @(negedge wclk); wrst_n = 1'b1;
        @(posedge wclk); #1;
        chks++;
        if ({rptr_ack, full, almost_full, wcount, overflow} !== 15'd0 || dut.r_rptr_s !== 11'(START)) begin
            errs++;
            $display("FAIL reset_release: outputs=%h rptr_s=%0d want 0 and 252",
                     {rptr_ack, full, almost_full, wcount, overflow}, dut.r_rptr_s);
        end
        ovf_clr = 1'b1; @(posedge wclk); #1; ovf_clr = 1'b0;
        chks++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_ovfclr: overflow=%b want 0", overflow);
        end
    endtask

    task automatic do_writes(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            m_cnt++;
            q.push_back('{11'(m_cnt), m_cnt == DEPTH, m_cnt >= AF});
            w_en = 1'b1;
            @(posedge wclk); #1;
            pop_check(nm);
        end
        w_en = 1'b0;
    endtask

    task automatic test_fill();
        do_writes(DEPTH, "fill");
        chks++;
        if (wptr !== 10'(START) || dut.r_wlap !== 1'b1) begin
            errs++;
            $display("FAIL fill_wrap: wptr=%0d wlap=%b want 252 and 1", wptr, dut.r_wlap);
        end
    endtask

    task automatic test_overflow();
        w_en = 1'b1;
        @(posedge wclk); #1;
        chks++;
        if (overflow !== 1'b1 || wcount !== 11'(DEPTH) || full !== 1'b1) begin
            errs++;
            $display("FAIL ovf_set: ovf=%b cnt=%0d full=%b want 1 520 1", overflow, wcount, full);
        end
        ovf_clr = 1'b1;
        @(posedge wclk); #1;
        chks++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_set_wins: overflow=%b want 1", overflow);
        end
        w_en = 1'b0;
        @(posedge wclk); #1;
        ovf_clr = 1'b0;
        chks++;
        if (overflow !== 1'b0 || wcount !== 11'(DEPTH)) begin
            errs++;
            $display("FAIL ovf_clr: ovf=%b cnt=%0d want 0 520", overflow, wcount);
        end
    endtask

    task automatic do_xfer(input logic [10:0] data, input int exp_cnt, input string nm);
        logic prev_ack;
        prev_ack  = rptr_ack;
        rptr_data = data;
        rptr_req  = ~rptr_req;
        m_cnt     = exp_cnt;
        q.push_back('{11'(exp_cnt), exp_cnt == DEPTH, exp_cnt >= AF});
        repeat (2) @(posedge wclk);
        #1;
        chks++;
        if (rptr_ack !== prev_ack) begin
            errs++;
            $display("FAIL %s_early: ack=%b want %b before 3rd edge", nm, rptr_ack, prev_ack);
        end
        @(posedge wclk); #1;
        chks++;
        if (rptr_ack !== rptr_req) begin
            errs++;
            $display("FAIL %s_ack: ack=%b want %b", nm, rptr_ack, rptr_req);
        end
        pop_check(nm);
    endtask

    task automatic test_laps();
        do_xfer({1'b0, 10'd352}, 420, "xfer_unfull");
        do_writes(10, "wr_to_262");
        do_xfer({1'b0, 10'd762}, 20, "lap_mismatch");
        do_writes(38, "wr_to_300");
        do_xfer({1'b1, 10'd260}, 40, "lap_match");
    endtask

    task automatic test_reset_midxfer();
        int toggles;
        logic last;
        do_xfer({1'b1, 10'd300}, 0, "drain");
        rptr_data = 11'(START);
        rptr_req  = 1'b1;
        @(posedge wclk); #1;
        wrst_n = 1'b0;
        #1;
        chks++;
        if ({rptr_ack, full, almost_full, wcount, overflow} !== 15'd0) begin
            errs++;
            $display("FAIL rst_mid: outputs=%h want 0", {rptr_ack, full, almost_full, wcount, overflow});
        end
        wrst_n = 1'b1;
        repeat (3) @(posedge wclk);
        #1;
        chks++;
        if (rptr_ack !== 1'b1 || wcount !== 11'd0 || full !== 1'b0) begin
            errs++;
            $display("FAIL rst_recap: ack=%b cnt=%0d full=%b want 1 0 0", rptr_ack, wcount, full);
        end
        toggles = 0;
        last = rptr_ack;
        for (int i = 0; i < 10; i++) begin
            @(posedge wclk); #1;
            if (rptr_ack !== last) toggles++;
            last = rptr_ack;
        end
        chks++;
        if (toggles != 0) begin
            errs++;
            $display("FAIL rst_single_ack: extra ack toggles=%0d want 0", toggles);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_laps();
        test_reset_midxfer();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
